// File: rtl/tx_symbol_scheduler_pkg.sv
// Shared constants and encodings for the transmit symbol scheduler.
// The symbol defaults are the RD- encodings; the top level lets them be overridden.
package tx_symbol_scheduler_pkg;

    localparam int SYM_W  = 10;
    localparam int SLOTS  = 10;
    localparam int CNT_W  = 4;
    localparam int SCNT_W = 10;

    localparam logic [SYM_W-1:0] COM_SYM_DEF = 10'h0FA;
    localparam logic [SYM_W-1:0] SKP_SYM_DEF = 10'h0F4;
    localparam logic [SYM_W-1:0] TS_SYM_DEF  = 10'h2AA;
    localparam logic [SYM_W-1:0] IDL_SYM_DEF = 10'h274;

    localparam logic [1:0] SRC_IDLE = 2'd0;
    localparam logic [1:0] SRC_DATA = 2'd1;
    localparam logic [1:0] SRC_TS   = 2'd2;
    localparam logic [1:0] SRC_SKP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TS   = 2'd2,
        ST_SKP  = 2'd3
    } state_t;

endpackage

// File: rtl/tx_slot_counter.sv
// Bit-slot counter aligned to the serializer load period, plus the symbol
// counter that paces SKP insertion. Emits boundary and skip_expire pulses.
module tx_slot_counter
    import tx_symbol_scheduler_pkg::*;
#(
    parameter int SKIP_INTERVAL = 16
) (
    input  logic TRANSCLK,
    input  logic RESET,
    output logic boundary,
    output logic skip_expire
);

    logic [CNT_W-1:0]  cnt;
    logic [SCNT_W-1:0] sym_cnt;

    assign boundary    = (cnt == CNT_W'(SLOTS - 1));
    assign skip_expire = boundary && (sym_cnt == SCNT_W'(SKIP_INTERVAL - 1));

    always_ff @(posedge TRANSCLK or posedge RESET) begin
        if (RESET) begin
            cnt     <= '0;
            sym_cnt <= '0;
        end else begin
            if (boundary) begin
                cnt     <= '0;
                sym_cnt <= skip_expire ? '0 : sym_cnt + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Picks the next 10-bit symbol at every serializer load boundary:
// SKP sets, then TS sets, then requester data, then idle fill.
module tx_symbol_scheduler
    import tx_symbol_scheduler_pkg::*;
#(
    parameter int               SKIP_INTERVAL = 16,
    parameter logic [SYM_W-1:0] COM_SYM       = COM_SYM_DEF,
    parameter logic [SYM_W-1:0] SKP_SYM       = SKP_SYM_DEF,
    parameter logic [SYM_W-1:0] TS_SYM        = TS_SYM_DEF,
    parameter logic [SYM_W-1:0] IDL_SYM       = IDL_SYM_DEF
) (
    input  logic             TRANSCLK,
    input  logic             RESET,
    input  logic             train_req,
    input  logic             data_valid,
    input  logic [SYM_W-1:0] data_in,
    output logic             data_ready,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_load,
    output logic [1:0]       cur_src,
    output logic             skip_pending,
    output logic [1:0]       state_dbg
);

    // Handshake: a symbol transfers on the rising TRANSCLK edge where
    // data_valid && data_ready; data_ready is only ever high while cnt==9.

    logic   boundary;
    logic   skip_expire;
    state_t state;
    logic [1:0] set_idx;
    logic   mid_set;

    tx_slot_counter #(
        .SKIP_INTERVAL (SKIP_INTERVAL)
    ) u_slot_counter (
        .TRANSCLK    (TRANSCLK),
        .RESET       (RESET),
        .boundary    (boundary),
        .skip_expire (skip_expire)
    );

    // set_idx counts symbols already sent in the current set; it wraps to 0
    // after the third payload, which marks the set as complete.
    assign mid_set    = ((state == ST_TS) || (state == ST_SKP)) && (set_idx != 2'd0);
    assign data_ready = boundary && !mid_set && !skip_pending && !train_req;
    assign state_dbg  = state;

    always_ff @(posedge TRANSCLK or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            set_idx      <= 2'd0;
            sym_out      <= IDL_SYM;
            sym_load     <= 1'b0;
            cur_src      <= SRC_IDLE;
            skip_pending <= 1'b0;
        end else begin
            sym_load <= boundary;
            if (boundary) begin
                if (mid_set) begin
                    sym_out <= (state == ST_TS) ? TS_SYM : SKP_SYM;
                    set_idx <= set_idx + 2'd1;
                end else if (skip_pending) begin
                    state        <= ST_SKP;
                    sym_out      <= COM_SYM;
                    cur_src      <= SRC_SKP;
                    set_idx      <= 2'd1;
                    skip_pending <= 1'b0;
                end else if (train_req) begin
                    state   <= ST_TS;
                    sym_out <= COM_SYM;
                    cur_src <= SRC_TS;
                    set_idx <= 2'd1;
                end else if (data_valid) begin
                    state   <= ST_DATA;
                    sym_out <= data_in;
                    cur_src <= SRC_DATA;
                    set_idx <= 2'd0;
                end else begin
                    state   <= ST_IDLE;
                    sym_out <= IDL_SYM;
                    cur_src <= SRC_IDLE;
                    set_idx <= 2'd0;
                end
            end
            // An expiry never coincides with a SKP start, so setting last is safe.
            if (skip_expire) begin
                skip_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Randomized bench for tx_symbol_scheduler against a queue-based symbol model.
module tb_tx_symbol_scheduler;

    localparam int         SI      = 5;
    localparam logic [9:0] COM     = 10'h0FA;
    localparam logic [9:0] SKP     = 10'h0F4;
    localparam logic [9:0] TSS     = 10'h2AA;
    localparam logic [9:0] IDL     = 10'h274;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_TS    = 2'd2;
    localparam logic [1:0] S_SKP   = 2'd3;

    logic       TRANSCLK = 1'b0;
    logic       RESET = 1'b0;
    logic       train_req = 1'b0;
    logic       data_valid = 1'b0;
    logic [9:0] data_in = '0;
    logic       data_ready;
    logic [9:0] sym_out;
    logic       sym_load;
    logic [1:0] cur_src;
    logic       skip_pending;
    logic [1:0] state_dbg;

    int total = 0;
    int bad = 0;

    // model state
    int          m_cnt;
    int          nb;
    bit          m_owed;
    logic [9:0]  e_sym;
    logic        e_load;
    logic [1:0]  e_src;
    logic        e_ready;
    logic [11:0] set_q[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  next_data = 10'd1;
    bit          tr_ctl = 1'b0;
    int          dv_mode = 0;

    tx_symbol_scheduler #(
        .SKIP_INTERVAL (SI)
    ) dut (
        .TRANSCLK     (TRANSCLK),
        .RESET        (RESET),
        .train_req    (train_req),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .data_ready   (data_ready),
        .sym_out      (sym_out),
        .sym_load     (sym_load),
        .cur_src      (cur_src),
        .skip_pending (skip_pending),
        .state_dbg    (state_dbg)
    );

    always #5 TRANSCLK = ~TRANSCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        nb     = 0;
        m_owed = 1'b0;
        e_sym  = IDL;
        e_load = 1'b0;
        e_src  = S_IDLE;
        set_q.delete();
        exp_q.delete();
    endtask

    task automatic start_set(input logic [1:0] src, input logic [9:0] payload);
        e_sym = COM;
        e_src = src;
        repeat (3) set_q.push_back({src, payload});
    endtask

    task automatic reset_dut();
        RESET = 1'b1;
        #1;
        check_val("rst_sym_out", sym_out, IDL);
        check_val("rst_sym_load", sym_load, 0);
        check_val("rst_skip_pending", skip_pending, 0);
        check_val("rst_cur_src", cur_src, S_IDLE);
        train_req  = 1'b0;
        data_valid = 1'b0;
        tr_ctl     = 1'b0;
        dv_mode    = 0;
        repeat (2) @(negedge TRANSCLK);
        RESET = 1'b0;
        model_reset();
    endtask

    // Called at a negedge: check, drive, predict the coming posedge, then advance.
    task automatic cycle();
        check_val("sym_out", sym_out, e_sym);
        check_val("sym_load", sym_load, e_load);
        check_val("cur_src", cur_src, e_src);
        check_val("skip_pending", skip_pending, m_owed);
        if (sym_load === 1'b1 && cur_src === S_DATA) begin
            if (exp_q.size() == 0) check_val("data_sb_count", exp_q.size(), 1);
            else check_val("data_sb", sym_out, exp_q.pop_front());
        end
        train_req  = tr_ctl;
        data_valid = (dv_mode == 1) ? 1'b1 : (dv_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        data_in    = next_data;
        #1;
        e_ready = (m_cnt == 9) && (set_q.size() == 0) && !m_owed && !train_req;
        check_val("data_ready", data_ready, e_ready);
        e_load = (m_cnt == 9);
        if (m_cnt == 9) begin
            if (set_q.size() > 0) begin
                {e_src, e_sym} = set_q.pop_front();
            end else if (m_owed) begin
                start_set(S_SKP, SKP);
                m_owed = 1'b0;
            end else if (train_req) begin
                start_set(S_TS, TSS);
            end else if (data_valid) begin
                e_sym = data_in;
                e_src = S_DATA;
                exp_q.push_back(data_in);
                next_data = next_data + 10'd1;
            end else begin
                e_sym = IDL;
                e_src = S_IDLE;
            end
            if (nb % SI == SI - 1) m_owed = 1'b1;
            nb++;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        @(negedge TRANSCLK);
    endtask

    initial begin
        bit found;
        #2;
        reset_dut();

        // idle fill after reset
        repeat (40) cycle();

        // one TS set, with the skip interval expiring on its second symbol
        reset_dut();
        repeat (30) cycle();
        tr_ctl = 1'b1;
        repeat (15) cycle();
        tr_ctl = 1'b0;
        repeat (60) cycle();

        // continuous data with periodic SKP insertion
        dv_mode = 1;
        repeat (80) cycle();

        // reset in the middle of a SKP set
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle();
            if (m_cnt == 5 && e_src == S_SKP && set_q.size() == 2) found = 1'b1;
        end
        check_val("skp_reset_reached", found, 1);
        reset_dut();
        repeat (20) cycle();

        // random traffic
        dv_mode = 2;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) tr_ctl = !tr_ctl;
            if ($urandom_range(0, 199) == 0) dv_mode = (dv_mode == 2) ? 1 : 2;
            cycle();
        end
        tr_ctl = 1'b0;
        dv_mode = 0;
        repeat (60) cycle();
        check_val("data_sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
